ram_block_ctrl: RTL
===================

RAM_BLOCK_CTRL -- requirements
Module: ram_block_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the byte width of the RAM data and of the stream data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the RAM address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
  clk  in  1  sole clock; all logic on rising edge
  rst  in  1  synchronous, active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
  cmd_write  in  1  1=write transfer, 0=read transfer
  cmd_addr  in  ADDR_WIDTH  start byte address
  cmd_len  in  ADDR_WIDTH  byte count; 0=no-op
  wr_data  in  DATA_WIDTH  write-stream byte
  wr_valid  in  1  write byte offered
  wr_ready  out  1  write byte accepted when wr_valid&wr_ready
  rd_data  out  DATA_WIDTH  read-stream byte
  rd_valid  out  1  read byte offered
  rd_ready  in  1  read byte consumed when rd_valid&rd_ready
  rd_last  out  1  marks final byte of a read transfer
  done  out  1  one-cycle pulse at transfer completion
  we_a, we_b  out  1  RAM port A/B write enables
  addr_a, addr_b  out  ADDR_WIDTH  RAM port A/B addresses
  data_a, data_b  out  DATA_WIDTH  RAM port A/B write data
  q_a, q_b  in  DATA_WIDTH  RAM port A/B read data, valid one clk after the address is presented

Function
REQ-004 The FSM SHALL have the states IDLE, WR, WR_ISSUE, RD_ADDR, RD_CAP and RD_OUT.
REQ-005 In IDLE the block SHALL hold cmd_ready=1 and drive wr_ready=0, rd_valid=0, we_a=0 and we_b=0.
REQ-006 On command accept, the block SHALL latch ptr=cmd_addr and remaining=cmd_len, then go to WR if cmd_write=1 or to RD_ADDR if cmd_write=0.
REQ-007 On accept of a command with cmd_len=0, the block SHALL stay in IDLE and pulse done the next cycle.
REQ-008 In WR the block SHALL drive wr_ready=1 and accept bytes in order, the first byte of a pair going to data_a and the second to data_b.
REQ-009 After the second byte of a pair, or after the final byte when remaining is odd, the block SHALL enter WR_ISSUE for exactly one cycle with wr_ready=0.
REQ-010 In WR_ISSUE the block SHALL drive addr_a=ptr and addr_b=ptr+1 modulo 2^ADDR_WIDTH.
REQ-011 In WR_ISSUE the block SHALL drive we_a=1, and SHALL drive we_b=1 only for a full pair.
REQ-012 After WR_ISSUE the block SHALL update ptr+=2 and remaining-=2, saturating remaining at 0.
REQ-013 After WR_ISSUE the block SHALL return to WR if remaining>0, otherwise go to IDLE and pulse done in the same cycle as the IDLE entry.
REQ-014 In RD_ADDR the block SHALL drive addr_a=ptr and addr_b=ptr+1 (wrapped) for one cycle with we_a=0 and we_b=0, then go to RD_CAP.
REQ-015 In RD_CAP the block SHALL register q_a into buf0 and q_b into buf1, and SHALL set pair=1 if remaining>=2.
REQ-016 In RD_OUT the block SHALL present buf0 and then, if pair=1, buf1 on rd_data with rd_valid=1, advancing to the next byte only on a rd_valid&rd_ready handshake.
REQ-017 In RD_OUT rd_data and rd_last SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-018 The block SHALL assert rd_last with the byte that brings remaining to 0.
REQ-019 After the last byte of a pair in RD_OUT, the block SHALL update ptr+=2 and remaining-=2, then return to RD_ADDR if remaining>0, otherwise go to IDLE and pulse done.
REQ-020 For an odd final byte the block SHALL not use port B data, and addr_b is don't-care in that case.
REQ-021 In WR, WR_ISSUE, RD_ADDR, RD_CAP and RD_OUT the block SHALL hold cmd_ready=0, so commands never overlap.
REQ-022 Outside WR_ISSUE the block SHALL hold we_a=0 and we_b=0, and the write enables SHALL never be asserted during a read transfer.
REQ-023 The ptr+1 address SHALL wrap, so that 0x3FF+1=0x000 at the default ADDR_WIDTH, and transfers SHALL wrap through the end of RAM.

Reset
REQ-024 A rst sampled high SHALL force the state to IDLE, cmd_ready=1, and wr_ready, rd_valid, rd_last, done, we_a and we_b to 0.
REQ-025 A rst sampled high SHALL clear ptr, remaining, buf0, buf1, addr_a, addr_b, data_a and data_b to 0.
REQ-026 A reset asserted mid-transfer SHALL abort the transfer with no done pulse and no further RAM write.

Verification
REQ-027 Write cmd addr=0x000 len=4 with bytes 54,68,69,73 -> WR_ISSUE cycles (a=0/54, b=1/68 with we_a=we_b=1) then (a=2/69, b=3/73), then one done pulse.
REQ-028 Read cmd addr=0x000 len=4 after the REQ-027 write -> rd_data sequence 54,68,69,73 with rd_last only on 73, then done.
REQ-029 Write len=3 at 0x3FE with bytes 41,42,43 -> pair writes to 0x3FE/0x3FF, then a port-A-only write of 43 at 0x000 with we_b=0; a read-back returns 41,42,43.
REQ-030 Command with cmd_len=0 -> no RAM access, done the next cycle, cmd_ready stays 1.
REQ-031 Read len=2 with rd_ready held low for 5 cycles -> rd_valid=1 and the first byte held stable for all 5 cycles, with no byte lost or duplicated.
REQ-032 rst pulsed after the first byte of a 4-byte write -> no we pulse follows, done stays 0, cmd_ready=1 the next cycle.

Source files
------------

// File: rtl/ram_block_ctrl.sv
// Byte-stream to dual-port RAM transfer controller: packs write bytes into
// port A/B pairs and unpacks paired reads back into an ordered read stream.
module ram_block_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic                  we_a,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b
);

    // state    | meaning
    // IDLE     | waiting for a command, cmd_ready high
    // WR       | collecting up to two write bytes
    // WR_ISSUE | one-cycle RAM write of the collected pair / odd byte
    // RD_ADDR  | presenting ptr / ptr+1 to the RAM
    // RD_CAP   | capturing q_a / q_b into buf0 / buf1
    // RD_OUT   | streaming buf0 then (if pair) buf1
    typedef enum logic [2:0] {
        IDLE, WR, WR_ISSUE, RD_ADDR, RD_CAP, RD_OUT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q, rem_q;
    logic [ADDR_WIDTH-1:0]   ptr_d, rem_d;
    logic [DATA_WIDTH-1:0]   buf0_q, buf1_q;
    logic                    pair_q;
    logic                    half_q;   // second byte of the pair is current
    logic                    cmd_ready_q, wr_ready_q, rd_valid_q, rd_last_q, done_q;
    logic                    we_a_q, we_b_q;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_b_q;
    logic [DATA_WIDTH-1:0]   data_a_q, data_b_q;

    assign ptr_d = ptr_q + TWO;
    assign rem_d = (rem_q >= TWO) ? (rem_q - TWO) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            pair_q      <= 1'b0;
            half_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            we_a_q      <= 1'b0;
            we_b_q      <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        ptr_q  <= cmd_addr;
                        rem_q  <= cmd_len;
                        half_q <= 1'b0;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else if (cmd_write) begin
                            state_q     <= WR;
                            cmd_ready_q <= 1'b0;
                            wr_ready_q  <= 1'b1;
                        end else begin
                            state_q     <= RD_ADDR;
                            cmd_ready_q <= 1'b0;
                            addr_a_q    <= cmd_addr;
                            addr_b_q    <= cmd_addr + ONE;
                        end
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        if (!half_q) begin
                            data_a_q <= wr_data;
                            if (rem_q == ONE) begin
                                state_q    <= WR_ISSUE;
                                wr_ready_q <= 1'b0;
                                we_a_q     <= 1'b1;
                                addr_a_q   <= ptr_q;
                                addr_b_q   <= ptr_q + ONE;
                            end else begin
                                half_q <= 1'b1;
                            end
                        end else begin
                            data_b_q   <= wr_data;
                            half_q     <= 1'b0;
                            state_q    <= WR_ISSUE;
                            wr_ready_q <= 1'b0;
                            we_a_q     <= 1'b1;
                            we_b_q     <= 1'b1;
                            addr_a_q   <= ptr_q;
                            addr_b_q   <= ptr_q + ONE;
                        end
                    end
                end
                WR_ISSUE: begin
                    we_a_q <= 1'b0;
                    we_b_q <= 1'b0;
                    ptr_q  <= ptr_d;
                    rem_q  <= rem_d;
                    if (rem_d != '0) begin
                        state_q    <= WR;
                        wr_ready_q <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    state_q <= RD_CAP;
                end
                RD_CAP: begin
                    buf0_q     <= q_a;
                    buf1_q     <= q_b;
                    pair_q     <= (rem_q >= TWO);
                    half_q     <= 1'b0;
                    rd_valid_q <= 1'b1;
                    rd_last_q  <= (rem_q == ONE);
                    state_q    <= RD_OUT;
                end
                RD_OUT: begin
                    if (rd_ready) begin
                        if (pair_q && !half_q) begin
                            half_q    <= 1'b1;
                            rd_last_q <= (rem_q == TWO);
                        end else begin
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            half_q     <= 1'b0;
                            ptr_q      <= ptr_d;
                            rem_q      <= rem_d;
                            if (rem_d != '0) begin
                                state_q  <= RD_ADDR;
                                addr_a_q <= ptr_d;
                                addr_b_q <= ptr_d + ONE;
                            end else begin
                                state_q     <= IDLE;
                                cmd_ready_q <= 1'b1;
                                done_q      <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // half_q only changes on a handshake, so rd_data is stable under backpressure
    assign rd_data   = half_q ? buf1_q : buf0_q;
    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign we_a      = we_a_q;
    assign we_b      = we_b_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign data_a    = data_a_q;
    assign data_b    = data_b_q;

endmodule
